// File: rtl/keypad_reader.sv
// keypad_reader
//   Polls a memory-mapped keypad controller, pulls key codes out of it,
//   assembles a four-digit hex entry and queues every raw key code.
//
//   Parameters
//     POLL_DIV    clk cycles spent waiting between successive ready polls
//     FIFO_DEPTH  raw key-code FIFO entries (power of two, >= 2)
//
//   Ports
//     clk           system clock, all state on its rising edge
//     rst_n         asynchronous active-low reset
//     kp_data       keypad bus: key code in [3:0] (kp_a0=0), ready in [0] (kp_a0=1)
//     kp_a0         keypad register select, 1 = status, 0 = data
//     kp_readyclr   one-cycle pulse that clears the keypad ready flag
//     entry         four hex digits being typed, newest in [3:0]
//     commit_value  last committed entry
//     commit_valid  one-cycle pulse when commit_value updates
//     key_code      FIFO head (valid while key_valid=1)
//     key_valid     FIFO not empty
//     key_pop       consumer pops the FIFO head this cycle
//     overflow      sticky flag: a key was dropped on a full FIFO
module keypad_reader #(
  parameter int POLL_DIV   = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] kp_data,
  output logic        kp_a0,
  output logic        kp_readyclr,
  output logic [15:0] entry,
  output logic [15:0] commit_value,
  output logic        commit_valid,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_pop,
  output logic        overflow
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(POLL_DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STATUS = 2'd1,
    DATA   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   poll_cnt;
  logic [3:0]      key_reg;

  // Upper data bits carry nothing of interest for this keypad.
  logic unused_bits;
  assign unused_bits = ^kp_data[15:4];

  // ---------------------------------------------------------------------------
  // Poll sequencer. kp_a0 / kp_readyclr are registered alongside the state so
  // kp_a0 is low exactly while in DATA and kp_readyclr high exactly in CLEAR.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT;
      poll_cnt    <= '0;
      kp_a0       <= 1'b1;
      kp_readyclr <= 1'b0;
      key_reg     <= 4'h0;
    end else begin
      case (state)
        WAIT: begin
          kp_a0       <= 1'b1;
          kp_readyclr <= 1'b0;
          if (poll_cnt == CNT_MAX) begin
            poll_cnt <= '0;
            state    <= STATUS;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        STATUS: begin
          if (kp_data[0]) begin
            state <= DATA;
            kp_a0 <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        DATA: begin
          key_reg     <= kp_data[3:0];
          state       <= CLEAR;
          kp_a0       <= 1'b1;
          kp_readyclr <= 1'b1;
        end
        CLEAR: begin
          kp_readyclr <= 1'b0;
          state       <= WAIT;
        end
        default: begin
          state       <= WAIT;
          kp_a0       <= 1'b1;
          kp_readyclr <= 1'b0;
        end
      endcase
    end
  end

  // The captured key is accepted during the CLEAR cycle.
  logic accept;
  assign accept = (state == CLEAR);

  // ---------------------------------------------------------------------------
  // Raw key FIFO, first-word fall-through.
  // ---------------------------------------------------------------------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          do_pop;
  logic          do_push;

  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  assign do_pop     = key_pop & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the key.
  assign do_push    = accept & (~fifo_full | do_pop);

  assign key_valid  = ~fifo_empty;
  assign key_code   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= key_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
      if (accept && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry assembly and commit. Runs on every accepted key, dropped or not.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry        <= 16'h0000;
      commit_value <= 16'h0000;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      if (accept) begin
        if (key_reg <= 4'h9) begin
          entry <= {entry[11:0], key_reg};
        end else if (key_reg == 4'hE) begin
          entry <= 16'h0000;
        end else if (key_reg == 4'hF) begin
          commit_value <= entry;
          commit_valid <= 1'b1;
          entry        <= 16'h0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_reader.sv
// tb_keypad_reader
//   Directed bench for keypad_reader with POLL_DIV=4, FIFO_DEPTH=4. A small
//   keypad model answers status reads with the ready flag and data reads with
//   the key code (upper bits filled with junk that must be ignored).
module tb_keypad_reader;

  logic        clk;
  logic        rst_n;
  logic [15:0] kp_data;
  logic        kp_a0;
  logic        kp_readyclr;
  logic [15:0] entry;
  logic [15:0] commit_value;
  logic        commit_valid;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pop;
  logic        overflow;

  logic        ready;
  logic [3:0]  key_val;

  int total;
  int bad;
  int a0_low_cnt;
  int clr_cnt;

  keypad_reader #(
    .POLL_DIV   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kp_data      (kp_data),
    .kp_a0        (kp_a0),
    .kp_readyclr  (kp_readyclr),
    .entry        (entry),
    .commit_value (commit_value),
    .commit_valid (commit_valid),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_pop      (key_pop),
    .overflow     (overflow)
  );

  assign kp_data = kp_a0 ? {15'h2A5C, ready} : {12'hFA0, key_val};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!kp_a0) a0_low_cnt++;
    if (kp_readyclr) clr_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Raise ready with key k and follow the handshake until kp_readyclr.
  // Optionally pop the FIFO head on the same edge that accepts the key.
  // Returns on the negedge just after the accept edge.
  task automatic press(input logic [3:0] k, input logic pop_on_accept);
    int   a0_lows;
    logic prev_low;
    bit   got;
    key_val  = k;
    ready    = 1'b1;
    a0_lows  = 0;
    prev_low = 1'b0;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (kp_readyclr) begin
        got = 1'b1;
        check("clr_follows_data", 16'(prev_low), 16'h1);
        check("a0_high_in_clear", 16'(kp_a0), 16'h1);
      end else begin
        prev_low = !kp_a0;
        if (!kp_a0) a0_lows++;
      end
    end
    if (!got) check("clr_timeout", 16'h0, 16'h1);
    check("a0_low_cycles", 16'(a0_lows), 16'h1);
    ready = 1'b0;
    if (pop_on_accept) key_pop = 1'b1;
    @(negedge clk);
    key_pop = 1'b0;
  endtask

  task automatic pop_expect(input logic [3:0] exp);
    check("pop_valid", 16'(key_valid), 16'h1);
    check("pop_code", 16'(key_code), 16'(exp));
    key_pop = 1'b1;
    @(negedge clk);
    key_pop = 1'b0;
  endtask

  initial begin
    int a0_base;
    int clr_base;
    bit seen;
    logic [3:0] seq [5];
    total      = 0;
    bad        = 0;
    a0_low_cnt = 0;
    clr_cnt    = 0;
    rst_n      = 1'b0;
    ready      = 1'b0;
    key_val    = 4'h0;
    key_pop    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a0", 16'(kp_a0), 16'h1);
    check("rst_readyclr", 16'(kp_readyclr), 16'h0);
    check("rst_entry", entry, 16'h0000);
    check("rst_commit_value", commit_value, 16'h0000);
    check("rst_commit_valid", 16'(commit_valid), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_overflow", 16'(overflow), 16'h0);
    rst_n = 1'b1;

    // Idle polling with ready low: never a data read, never a clear
    a0_base  = a0_low_cnt;
    clr_base = clr_cnt;
    repeat (20) @(negedge clk);
    check("idle_a0_low", 16'(a0_low_cnt - a0_base), 16'h0);
    check("idle_readyclr", 16'(clr_cnt - clr_base), 16'h0);

    // Single key 5
    press(4'h5, 1'b0);
    check("k5_code", 16'(key_code), 16'h5);
    check("k5_valid", 16'(key_valid), 16'h1);
    check("k5_entry", entry, 16'h0005);
    pop_expect(4'h5);
    check("k5_empty", 16'(key_valid), 16'h0);

    // Keys 1..5 then hash
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    for (int i = 0; i < 5; i++) begin
      press(seq[i], 1'b0);
      pop_expect(seq[i]);
    end
    check("seq_entry", entry, 16'h2345);
    press(4'hF, 1'b0);
    check("hash_commit_valid", 16'(commit_valid), 16'h1);
    check("hash_commit_value", commit_value, 16'h2345);
    check("hash_entry", entry, 16'h0000);
    @(negedge clk);
    check("hash_pulse_end", 16'(commit_valid), 16'h0);
    pop_expect(4'hF);

    // 7 then star
    press(4'h7, 1'b0);
    check("k7_entry", entry, 16'h0007);
    press(4'hE, 1'b0);
    check("star_entry", entry, 16'h0000);
    check("star_no_commit", 16'(commit_valid), 16'h0);
    check("star_commit_value", commit_value, 16'h2345);
    pop_expect(4'h7);
    pop_expect(4'hE);
    check("star_empty", 16'(key_valid), 16'h0);

    // Pop while empty is ignored
    key_pop = 1'b1;
    @(negedge clk);
    key_pop = 1'b0;
    check("empty_pop_valid", 16'(key_valid), 16'h0);

    // Fill, overflow, push+pop while full
    press(4'h1, 1'b0);
    press(4'h2, 1'b0);
    press(4'h3, 1'b0);
    press(4'h4, 1'b0);
    check("full_no_ovf", 16'(overflow), 16'h0);
    press(4'h5, 1'b0);
    check("ovf_set", 16'(overflow), 16'h1);
    check("ovf_entry", entry, 16'h2345);
    press(4'h6, 1'b1);
    check("pushpop_entry", entry, 16'h3456);
    pop_expect(4'h2);
    pop_expect(4'h3);
    pop_expect(4'h4);
    pop_expect(4'h6);
    check("drain_empty", 16'(key_valid), 16'h0);
    check("ovf_sticky", 16'(overflow), 16'h1);

    // Asynchronous reset in the middle of DATA
    press(4'h8, 1'b0);
    clr_base = clr_cnt;
    key_val  = 4'hA;
    ready    = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!kp_a0) seen = 1'b1;
    end
    if (!seen) check("data_timeout", 16'h0, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a0", 16'(kp_a0), 16'h1);
    check("arst_readyclr", 16'(kp_readyclr), 16'h0);
    check("arst_key_valid", 16'(key_valid), 16'h0);
    check("arst_entry", entry, 16'h0000);
    check("arst_commit_value", commit_value, 16'h0000);
    check("arst_commit_valid", 16'(commit_valid), 16'h0);
    check("arst_overflow", 16'(overflow), 16'h0);
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_clr", 16'(clr_cnt - clr_base), 16'h0);
    check("arst_no_push", 16'(key_valid), 16'h0);

    // Poller resumes after reset
    press(4'h9, 1'b0);
    check("resume_code", 16'(key_code), 16'h9);
    check("resume_entry", entry, 16'h0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
